// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Purpose  : Issue/writeback handshake bundle for the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exec_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_res;
    logic             res_wr;
    logic [3:0]       status;

    modport master (
        output in_valid, exec_cmd, val1, val2, set_flags, out_ready,
        input  in_ready, out_valid, alu_res, res_wr, status
    );

    modport slave (
        input  in_valid, exec_cmd, val1, val2, set_flags, out_ready,
        output in_ready, out_valid, alu_res, res_wr, status
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Purpose  : Registered execute-stage ALU with iterative shift-add multiplier
//            and an NZCV status register (bit order {Z,C,N,V}).
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);

    localparam logic [3:0] c_op_mov = 4'b0001;
    localparam logic [3:0] c_op_mvn = 4'b1001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_adc = 4'b0011;
    localparam logic [3:0] c_op_sub = 4'b0100;
    localparam logic [3:0] c_op_sbc = 4'b0101;
    localparam logic [3:0] c_op_and = 4'b0110;
    localparam logic [3:0] c_op_orr = 4'b0111;
    localparam logic [3:0] c_op_eor = 4'b1000;
    localparam logic [3:0] c_op_mul = 4'b1010;
    localparam logic [3:0] c_op_cmp = 4'b1100;
    localparam logic [3:0] c_op_tst = 4'b1110;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res;
    logic             r_res_wr;
    logic [3:0]       r_flags;
    logic             r_set_flags;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_flag_c;
    logic             w_flag_v;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic             w_set_cv;
    logic             w_known;
    logic             w_wr;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [3:0]       w_new_flags;
    logic [WIDTH-1:0] w_partial;

    assign w_flag_c = r_flags[2];
    assign w_flag_v = r_flags[0];

    // Subtraction is folded into the adder as val1 + ~val2 + cin.
    always_comb begin
        w_b_eff  = bus.val2;
        w_cin    = 1'b0;
        w_set_cv = 1'b0;
        unique case (bus.exec_cmd)
            c_op_add: w_set_cv = 1'b1;
            c_op_adc: begin w_set_cv = 1'b1; w_cin = w_flag_c; end
            c_op_sub,
            c_op_cmp: begin w_set_cv = 1'b1; w_b_eff = ~bus.val2; w_cin = 1'b1; end
            c_op_sbc: begin w_set_cv = 1'b1; w_b_eff = ~bus.val2; w_cin = w_flag_c; end
            default:  ;
        endcase
    end

    assign w_sum = {1'b0, bus.val1} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf = (bus.val1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.val1[WIDTH-1]);

    always_comb begin
        w_res   = '0;
        w_wr    = 1'b1;
        w_known = 1'b1;
        unique case (bus.exec_cmd)
            c_op_mov: w_res = bus.val2;
            c_op_mvn: w_res = ~bus.val2;
            c_op_add,
            c_op_adc,
            c_op_sub,
            c_op_sbc: w_res = w_sum[WIDTH-1:0];
            c_op_cmp: begin w_res = w_sum[WIDTH-1:0]; w_wr = 1'b0; end
            c_op_and: w_res = bus.val1 & bus.val2;
            c_op_orr: w_res = bus.val1 | bus.val2;
            c_op_eor: w_res = bus.val1 ^ bus.val2;
            c_op_tst: begin w_res = bus.val1 & bus.val2; w_wr = 1'b0; end
            default:  begin w_wr = 1'b0; w_known = 1'b0; end
        endcase
    end

    assign w_new_flags = {(w_res == '0),
                          w_set_cv ? w_sum[WIDTH] : w_flag_c,
                          w_res[WIDTH-1],
                          w_set_cv ? w_ovf : w_flag_v};

    assign w_partial = r_acc + (r_mul_b[0] ? r_mul_a : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_res_wr    <= 1'b0;
            r_flags     <= 4'b0000;
            r_set_flags <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready  <= 1'b0;
                        r_set_flags <= bus.set_flags;
                        if (bus.exec_cmd == c_op_mul) begin
                            r_mul_a <= bus.val1;
                            r_mul_b <= bus.val2;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_BUSY;
                        end else begin
                            r_res       <= w_res;
                            r_res_wr    <= w_wr;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                            if (bus.set_flags && w_known) begin
                                r_flags <= w_new_flags;
                            end
                        end
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_partial;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + c_cnt_one;
                    // The last step's partial sum is the full product.
                    if (r_cnt == c_cnt_last) begin
                        r_res       <= w_partial;
                        r_res_wr    <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                        if (r_set_flags) begin
                            r_flags <= {(w_partial == '0), w_flag_c,
                                        w_partial[WIDTH-1], w_flag_v};
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_res   = r_res;
    assign bus.res_wr    = r_res_wr;
    assign bus.status    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Purpose  : Directed, table-driven self-checking bench for seq_alu (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int WIDTH = 32;

    localparam logic [3:0] c_mov = 4'b0001, c_mvn = 4'b1001, c_add = 4'b0010;
    localparam logic [3:0] c_adc = 4'b0011, c_sub = 4'b0100, c_sbc = 4'b0101;
    localparam logic [3:0] c_and = 4'b0110, c_orr = 4'b0111, c_eor = 4'b1000;
    localparam logic [3:0] c_mul = 4'b1010, c_cmp = 4'b1100, c_tst = 4'b1110;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic [31:0] res;
        logic        wr;
        logic [3:0]  st;
        int          lat;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one op, then waits (bounded) for out_valid; lat counts negedges after accept.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic sf, output int lat, output logic busy_ok,
                         output logic was_ready);
        @(negedge clk);
        was_ready     = bus.in_ready;
        bus.exec_cmd  = cmd;
        bus.val1      = a;
        bus.val2      = b;
        bus.set_flags = sf;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic was_ready;
        logic late;

        //            cmd    a             b             sf    res           wr    {Z,C,N,V} lat
        vecs[0]  = '{c_add, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 4'b1100, 1};
        vecs[1]  = '{c_add, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 4'b0011, 1};
        vecs[2]  = '{c_adc, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4'b1000, 1};
        vecs[3]  = '{c_sub, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 4'b1100, 1};
        vecs[4]  = '{c_sub, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b1, 4'b0010, 1};
        vecs[5]  = '{c_sbc, 32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFD, 1'b1, 4'b0010, 1};
        vecs[6]  = '{c_mov, 32'h00000000, 32'h00000055, 1'b0, 32'h00000055, 1'b1, 4'b0010, 1};
        vecs[7]  = '{c_add, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 4'b1101, 1};
        vecs[8]  = '{c_mvn, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 4'b0111, 1};
        vecs[9]  = '{c_and, 32'h0000F0F0, 32'h00000F0F, 1'b1, 32'h00000000, 1'b1, 4'b1101, 1};
        vecs[10] = '{c_orr, 32'h0000F0F0, 32'h00000F0F, 1'b0, 32'h0000FFFF, 1'b1, 4'b1101, 1};
        vecs[11] = '{c_eor, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'hF0F00F0F, 1'b1, 4'b0111, 1};
        vecs[12] = '{c_tst, 32'h00000008, 32'h00000004, 1'b1, 32'h00000000, 1'b0, 4'b1101, 1};
        vecs[13] = '{c_cmp, 32'h00000003, 32'h00000007, 1'b1, 32'hFFFFFFFC, 1'b0, 4'b0010, 1};
        vecs[14] = '{4'b0000, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 4'b0010, 1};
        vecs[15] = '{4'b1111, 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 4'b0010, 1};
        vecs[16] = '{c_add, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b1, 4'b0010, 1};
        vecs[17] = '{c_sub, 32'h00000009, 32'h00000002, 1'b1, 32'h00000007, 1'b1, 4'b0100, 1};
        vecs[18] = '{c_adc, 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b1, 4'b0000, 1};
        vecs[19] = '{c_sub, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 4'b0101, 1};
        vecs[20] = '{c_mov, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 4'b1101, 1};
        vecs[21] = '{c_mul, 32'h00001234, 32'h00000010, 1'b1, 32'h00012340, 1'b1, 4'b0101, 33};
        vecs[22] = '{c_mul, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b1, 4'b0101, 33};
        vecs[23] = '{c_mul, 32'h80000000, 32'h00000002, 1'b1, 32'h00000000, 1'b1, 4'b1101, 33};
        vecs[24] = '{4'b1101, 32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 4'b1101, 1};
        vecs[25] = '{c_adc, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b1, 4'b0011, 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.exec_cmd  = 4'b0000;
        bus.val1      = '0;
        bus.val2      = '0;
        bus.set_flags = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'h1);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_alu_res",   64'(bus.alu_res),   64'h0);
        check("rst_res_wr",    64'(bus.res_wr),    64'h0);
        check("rst_status",    64'(bus.status),    64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].sf, lat, busy_ok, was_ready);
            check($sformatf("v%0d_ready", i),   64'(was_ready),      64'h1);
            check($sformatf("v%0d_latency", i), 64'(lat),            64'(vecs[i].lat));
            check($sformatf("v%0d_busy", i),    64'(busy_ok),        64'h1);
            check($sformatf("v%0d_res", i),     64'(bus.alu_res),    64'(vecs[i].res));
            check($sformatf("v%0d_res_wr", i),  64'(bus.res_wr),     64'(vecs[i].wr));
            check($sformatf("v%0d_status", i),  64'(bus.status),     64'(vecs[i].st));
            retire();
        end

        // CMP held in DONE: outputs stable, stray in_valid pulses ignored.
        issue(c_cmp, 32'h7, 32'h7, 1'b1, lat, busy_ok, was_ready);
        check("cmp_latency", 64'(lat), 64'h1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), 64'(bus.out_valid), 64'h1);
            check($sformatf("hold%0d_res", k),   64'(bus.alu_res),   64'h0);
            check($sformatf("hold%0d_wr", k),    64'(bus.res_wr),    64'h0);
            check($sformatf("hold%0d_ready", k), 64'(bus.in_ready),  64'h0);
            bus.exec_cmd  = c_add;
            bus.val1      = 32'h1;
            bus.val2      = 32'h1;
            bus.set_flags = 1'b1;
            bus.in_valid  = (k == 1 || k == 3);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("hold_status", 64'(bus.status), 64'hC);
        retire();
        check("post_hold_valid", 64'(bus.out_valid), 64'h0);
        check("post_hold_ready", 64'(bus.in_ready),  64'h1);

        // Reset during MUL busy phase.
        @(negedge clk);
        bus.exec_cmd  = c_mul;
        bus.val1      = 32'h3;
        bus.val2      = 32'h5;
        bus.set_flags = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_mul_busy", 64'(bus.in_ready), 64'h0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'h0);
        check("arst_in_ready",  64'(bus.in_ready),  64'h1);
        check("arst_status",    64'(bus.status),    64'h0);
        check("arst_alu_res",   64'(bus.alu_res),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(c_add, 32'h2, 32'h3, 1'b0, lat, busy_ok, was_ready);
        check("after_rst_latency", 64'(lat),         64'h1);
        check("after_rst_res",     64'(bus.alu_res), 64'h5);
        check("after_rst_status",  64'(bus.status),  64'h0);
        retire();
        late = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) late = 1'b1;
        end
        check("no_stale_mul", 64'(late), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
